// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes (common with the transmitter) and default bit timing.
package uart_pkg;

    localparam int CLK_PER_BIT_DEFAULT = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        START  = 3'b001,
        DATA   = 3'b010,
        STOP   = 3'b011,
        RESYNC = 3'b100
    } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous input.
// Both flops reset to 1 so that an idle-high line is seen as idle.
module uart_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, LSB first: start-bit qualification at mid-bit, data and stop sampling
// one bit period apart, one-cycle valid / framing-error pulses.
//
// state  | meaning
// IDLE   | line idle, waiting for a low level on rx_sync
// START  | timing to the middle of the start bit to reject glitches
// DATA   | sampling eight data bits, one per Clk_per_bit cycles
// STOP   | sampling the stop bit; good frame or framing error
// RESYNC | waiting for the line to return high before re-arming
module uart_receiver
    import uart_pkg::*;
#(
    parameter int Clk_per_bit = CLK_PER_BIT_DEFAULT
) (
    input  logic       MasterClk,
    input  logic       MasterRst_n,
    input  logic       rx_serial,
    output logic       rx_active,
    output logic       rx_datavalid,
    output logic [7:0] Received_Byte,
    output logic       framing_error
);

    localparam logic [7:0] HALF_CNT = 8'((Clk_per_bit - 1) / 2);
    localparam logic [7:0] LAST_CNT = 8'(Clk_per_bit - 1);

    logic        rx_sync;
    uart_state_e state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  byte_q, byte_d;
    logic        active_q, active_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;

    uart_sync2 u_sync (
        .clk   (MasterClk),
        .rst_n (MasterRst_n),
        .d     (rx_serial),
        .q     (rx_sync)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        byte_d   = byte_q;
        active_d = active_q;
        valid_d  = 1'b0;
        ferr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                idx_d = 3'd0;
                if (!rx_sync) begin
                    state_d  = START;
                    active_d = 1'b1;
                end
            end
            START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d = 8'd0;
                    if (!rx_sync) begin
                        state_d = DATA;
                    end else begin
                        active_d = 1'b0;
                        state_d  = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DATA: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d          = 8'd0;
                    shift_d[idx_q] = rx_sync;
                    if (idx_q == 3'd7) begin
                        idx_d   = 3'd0;
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            STOP: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d    = 8'd0;
                    active_d = 1'b0;
                    state_d  = RESYNC;
                    if (rx_sync) begin
                        byte_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            // A break (line held low) must not look like a new start bit.
            RESYNC: begin
                if (rx_sync) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                cnt_d    = 8'd0;
                idx_d    = 3'd0;
                active_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge MasterClk or negedge MasterRst_n) begin
        if (!MasterRst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            idx_q    <= 3'd0;
            shift_q  <= 8'd0;
            byte_q   <= 8'd0;
            active_q <= 1'b0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            byte_q   <= byte_d;
            active_q <= active_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
        end
    end

    assign rx_active     = active_q;
    assign rx_datavalid  = valid_q;
    assign Received_Byte = byte_q;
    assign framing_error = ferr_q;

endmodule
